// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester round-robin arbiter in front of one UART
// transmitter. A granted byte is launched with a level tx_send, completion is
// taken from tx_sent, and a per-transfer watchdog aborts a stalled transfer.
module uart_tx_arbiter #(
   parameter logic [31:0] TIMEOUT = 32'd100_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic [7:0] data0,
   output logic       ack0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       ack1,
   output logic       tx_send,
   output logic [7:0] tx_data,
   input  logic       tx_sent,
   input  logic       err_clr,
   output logic       busy,
   output logic       owner,
   output logic       timeout_err
);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, FINISH} state_t;

   state_t      state, state_nx;
   logic [31:0] cnt, cnt_nx;
   logic        last_owner, last_owner_nx;
   logic        tx_send_nx, ack0_nx, ack1_nx, owner_nx, timeout_err_nx;
   logic [7:0]  tx_data_nx;
   logic        to_hit;

   // Watchdog fires on the edge where the count has reached TIMEOUT-1.
   assign to_hit = (cnt == (TIMEOUT - 32'd1));

   // State register and registered outputs; reset abandons any transfer at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 32'd0;
         last_owner  <= 1'b1;
         tx_send     <= 1'b0;
         tx_data     <= 8'h00;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         owner       <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         last_owner  <= last_owner_nx;
         tx_send     <= tx_send_nx;
         tx_data     <= tx_data_nx;
         ack0        <= ack0_nx;
         ack1        <= ack1_nx;
         owner       <= owner_nx;
         busy        <= (state_nx != IDLE);
         timeout_err <= timeout_err_nx;
      end
   end

   // Next-state and next-output decode; an abort still ends in FINISH so the
   // owner always gets its ack, and a timeout outranks err_clr on the same edge.
   always_comb begin
      state_nx       = state;
      cnt_nx         = cnt;
      last_owner_nx  = last_owner;
      tx_send_nx     = tx_send;
      tx_data_nx     = tx_data;
      ack0_nx        = 1'b0;
      ack1_nx        = 1'b0;
      owner_nx       = owner;
      timeout_err_nx = err_clr ? 1'b0 : timeout_err;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               owner_nx   = (req0 && req1) ? ~last_owner : req1;
               tx_data_nx = owner_nx ? data1 : data0;
               tx_send_nx = 1'b1;
               cnt_nx     = 32'd0;
               state_nx   = LAUNCH;
            end
         end
         LAUNCH: begin
            if (to_hit) begin
               tx_send_nx     = 1'b0;
               timeout_err_nx = 1'b1;
               ack0_nx        = ~owner;
               ack1_nx        = owner;
               state_nx       = FINISH;
            end else begin
               cnt_nx = cnt + 32'd1;
               // Any sampled 0 counts as acceptance, even if the
               // transmitter was already busy when the grant happened.
               if (!tx_sent) begin
                  tx_send_nx = 1'b0;
                  state_nx   = WAIT_DONE;
               end
            end
         end
         WAIT_DONE: begin
            if (tx_sent) begin
               ack0_nx  = ~owner;
               ack1_nx  = owner;
               state_nx = FINISH;
            end else if (to_hit) begin
               timeout_err_nx = 1'b1;
               ack0_nx        = ~owner;
               ack1_nx        = owner;
               state_nx       = FINISH;
            end else begin
               cnt_nx = cnt + 32'd1;
            end
         end
         FINISH: begin
            last_owner_nx = owner;
            state_nx      = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic against a
// transfer-level reference model, with a UART transmitter responder.
module tb_uart_tx_arbiter;
   localparam logic [31:0] TO = 32'd16;

   logic       clk = 1'b0, rst = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0, tx_sent = 1'b1, err_clr = 1'b0;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
   logic       ack0, ack1, tx_send, busy, owner, timeout_err;
   logic [7:0] tx_data;

   uart_tx_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .data0(data0), .ack0(ack0),
      .req1(req1), .data1(data1), .ack1(ack1),
      .tx_send(tx_send), .tx_data(tx_data), .tx_sent(tx_sent),
      .err_clr(err_clr), .busy(busy), .owner(owner), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0, m_chk = 0, m_err = 0;

   // ---------------- reference model (transfer level) ----------------
   bit          m_on, m_low, m_fin, m_last, m_hit;
   int unsigned m_age;
   logic        e_send, e_ack0, e_ack1, e_owner, e_err;
   logic [7:0]  e_data;

   // A transfer is: grant, wait for the transmitter to accept (first low),
   // wait for it to go idle again, then one ack cycle; age caps the whole thing.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_on = 0; m_low = 0; m_fin = 0; m_last = 1; m_age = 0;
         e_send = 0; e_data = 8'h00; e_ack0 = 0; e_ack1 = 0; e_owner = 0; e_err = 0;
      end else begin
         m_hit = 0;
         e_ack0 = 0; e_ack1 = 0;
         if (m_fin) begin
            m_fin = 0; m_on = 0; m_last = e_owner;
         end else if (m_on) begin
            if (m_low && tx_sent) begin
               m_fin = 1; e_ack0 = !e_owner; e_ack1 = e_owner;
            end else if (m_age == TO - 1) begin
               m_hit = 1; e_send = 0; m_fin = 1; e_ack0 = !e_owner; e_ack1 = e_owner;
            end else begin
               if (!m_low && !tx_sent) begin m_low = 1; e_send = 0; end
               m_age = m_age + 1;
            end
         end else if (req0 || req1) begin
            e_owner = (req0 && req1) ? !m_last : req1;
            e_data  = e_owner ? data1 : data0;
            e_send  = 1; m_on = 1; m_low = 0; m_age = 0;
         end
         if (m_hit) e_err = 1;
         else if (err_clr) e_err = 0;
      end
   end

   // ---------------- transmitter responder ----------------
   bit stuck = 0, rand_mode = 0;
   int cfg_drop = 3, cfg_busy = 10, seen = 0, low_left = 0;

   // Accepts after cfg_drop cycles of tx_send, stays busy cfg_busy cycles;
   // in random mode it may also go busy on its own while not requested.
   always @(negedge clk) begin
      if (rst) begin
         tx_sent = 1'b1; seen = 0; low_left = 0;
      end else if (!tx_sent) begin
         if (low_left <= 1) tx_sent = 1'b1;
         else low_left = low_left - 1;
      end else if (tx_send && !stuck) begin
         seen = seen + 1;
         if (seen >= cfg_drop) begin tx_sent = 1'b0; low_left = cfg_busy; seen = 0; end
      end else if (!tx_send) begin
         seen = 0;
         if (rand_mode && $urandom_range(0, 29) == 0) begin
            tx_sent = 1'b0; low_left = $urandom_range(1, 8);
         end
      end
   end

   // ---------------- per-cycle compare and event log ----------------
   int         send_hi = 0, ack0_n = 0, ack1_n = 0;
   bit         terr_at_ack = 0;
   bit         ack_log[$];
   logic [7:0] byte_log[$];
   logic [13:0] act_v, exp_v;

   // Every cycle the registered outputs must equal the model's.
   always @(negedge clk) begin
      act_v = {tx_send, tx_data, ack0, ack1, busy, owner, timeout_err};
      exp_v = {e_send, e_data, e_ack0, e_ack1, m_on, e_owner, e_err};
      m_chk++;
      if (act_v !== exp_v) begin
         m_err++;
         if (m_err <= 20)
            $display("FAIL cycle_cmp t=%0t: got send=%b data=%h ack=%b%b busy=%b owner=%b err=%b, expected send=%b data=%h ack=%b%b busy=%b owner=%b err=%b",
                     $time, tx_send, tx_data, ack0, ack1, busy, owner, timeout_err,
                     e_send, e_data, e_ack0, e_ack1, m_on, e_owner, e_err);
      end
      if (tx_send) send_hi++;
      if (ack0) begin ack0_n++; ack_log.push_back(1'b0); byte_log.push_back(tx_data); terr_at_ack = timeout_err; end
      if (ack1) begin ack1_n++; ack_log.push_back(1'b1); byte_log.push_back(tx_data); terr_at_ack = timeout_err; end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Wait (bounded) until the total ack count reaches target; ends on a negedge.
   task automatic wait_acks(input int target, input int budget);
      int k;
      k = 0;
      while ((ack0_n + ack1_n) < target && k < budget) begin @(posedge clk); k++; end
      if ((ack0_n + ack1_n) < target) begin
         n_chk++; n_err++;
         $display("FAIL ack_wait: got %0d acks, expected %0d within %0d cycles", ack0_n + ack1_n, target, budget);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int base, s0, a0, a1, nb, k;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_send", tx_send, 0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      chk("rst_acks", {ack0, ack1}, 0);
      chk("rst_err", timeout_err, 0);
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);

      // Single request, 3-cycle accept, 10-cycle shift.
      base = ack0_n + ack1_n; s0 = send_hi; a0 = ack0_n;
      req0 = 1; data0 = 8'hA5;
      wait_acks(base + 1, 60);
      req0 = 0;
      repeat (2) @(negedge clk);
      chk("a5_byte", byte_log[$], 8'hA5);
      chk("a5_send_cycles", send_hi - s0, 3);
      chk("a5_ack0_pulses", ack0_n - a0, 1);
      chk("a5_busy_end", busy, 0);

      // Tie after reset: requester 0 first, then strict alternation.
      do_reset();
      base = ack0_n + ack1_n; nb = ack_log.size();
      req0 = 1; data0 = 8'h11; req1 = 1; data1 = 8'h22;
      wait_acks(base + 4, 200);
      req0 = 0; req1 = 0;
      for (int i = 0; i < 4; i++) begin
         chk("rr_order", (nb + i < ack_log.size()) ? ack_log[nb + i] : 1'bx, i % 2);
         chk("rr_byte", (nb + i < byte_log.size()) ? byte_log[nb + i] : 8'hxx, (i % 2) ? 8'h22 : 8'h11);
      end

      // Transmitter never accepts: watchdog abort, then err_clr.
      stuck = 1;
      base = ack0_n + ack1_n; s0 = send_hi; a0 = ack0_n;
      req0 = 1; data0 = 8'h5A;
      wait_acks(base + 1, 60);
      req0 = 0;
      chk("to_send_cycles", send_hi - s0, 16);
      chk("to_ack0_pulses", ack0_n - a0, 1);
      chk("to_err_set", timeout_err, 1);
      err_clr = 1;
      @(negedge clk);
      err_clr = 0;
      chk("to_err_clr", timeout_err, 0);

      // err_clr held across the timeout edge: the new timeout wins.
      base = ack0_n + ack1_n;
      err_clr = 1; req1 = 1; data1 = 8'h77;
      wait_acks(base + 1, 60);
      chk("clr_vs_timeout", terr_at_ack, 1);
      chk("clr_after", timeout_err, 0);
      err_clr = 0; req1 = 0; stuck = 0;
      @(negedge clk);

      // Reset while the transmitter is shifting.
      cfg_drop = 3; cfg_busy = 12;
      base = ack0_n + ack1_n; a0 = ack0_n; a1 = ack1_n;
      req0 = 1; data0 = 8'hC3;
      k = 0;
      while (!(busy && !tx_send) && k < 40) begin @(negedge clk); k++; end
      chk("rst_mid_reached_wait", busy && !tx_send, 1);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      chk("rst_mid_send", tx_send, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_data", tx_data, 8'h00);
      chk("rst_mid_owner", owner, 0);
      @(negedge clk);
      req0 = 0; req1 = 1; data1 = 8'h4B;
      @(posedge clk); #2 rst = 1'b0;
      wait_acks(base + 1, 60);
      req1 = 0;
      chk("rst_mid_no_ack0", ack0_n - a0, 0);
      chk("rst_mid_ack1", ack1_n - a1, 1);
      chk("rst_mid_byte", byte_log[$], 8'h4B);

      // Requester drops and corrupts its byte during LAUNCH.
      cfg_drop = 3; cfg_busy = 5;
      base = ack0_n + ack1_n; a0 = ack0_n; a1 = ack1_n;
      req1 = 1; data1 = 8'h3C;
      k = 0;
      while (!busy && k < 10) begin @(negedge clk); k++; end
      req1 = 0; data1 = 8'hFF;
      @(negedge clk);
      chk("drop_data_hold", tx_data, 8'h3C);
      wait_acks(base + 1, 60);
      repeat (3) @(negedge clk);
      chk("drop_byte", byte_log[$], 8'h3C);
      chk("drop_ack1", ack1_n - a1, 1);
      chk("drop_no_ack0", ack0_n - a0, 0);

      // Random traffic, random transmitter timing, random err_clr.
      rand_mode = 1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (!busy) begin cfg_drop = $urandom_range(1, 20); cfg_busy = $urandom_range(1, 20); end
         if (ack0) req0 = 0;
         else if (!req0 && $urandom_range(0, 3) == 0) begin req0 = 1; data0 = 8'($urandom); end
         if (ack1) req1 = 0;
         else if (!req1 && $urandom_range(0, 3) == 0) begin req1 = 1; data1 = 8'($urandom); end
         err_clr = ($urandom_range(0, 15) == 0);
      end
      @(negedge clk);
      req0 = 0; req1 = 0; err_clr = 0; rand_mode = 0;
      k = 0;
      while (busy && k < 60) begin @(negedge clk); k++; end
      chk("drain_idle", busy, 0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk + m_chk, n_err + m_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 32'd100_000: max clk cycles a granted transfer may wait for the transmitter before abort.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0  input  1  requester 0 transfer request, level; held until ack0.
REQ-005 data0  input  8  requester 0 byte; stable while req0 high.
REQ-006 ack0  output  1  one-cycle pulse: requester 0 transfer finished (sent or aborted).
REQ-007 req1  input  1  requester 1 transfer request, level; held until ack1.
REQ-008 data1  input  8  requester 1 byte; stable while req1 high.
REQ-009 ack1  output  1  one-cycle pulse: requester 1 transfer finished.
REQ-010 tx_send  output  1  level start request to UART transmitter.
REQ-011 tx_data  output  8  byte presented to UART transmitter.
REQ-012 tx_sent  input  1  transmitter status: 1 = idle/done, 0 = shifting.
REQ-013 err_clr  input  1  synchronous clear of timeout_err.
REQ-014 busy  output  1  1 whenever state is not IDLE.
REQ-015 owner  output  1  index of current/last granted requester.
REQ-016 timeout_err  output  1  sticky flag: a transfer was aborted on timeout.

Function
REQ-017 FSM states IDLE, LAUNCH, WAIT_DONE, FINISH; all outputs registered.
REQ-018 IDLE, no req: remain IDLE; tx_send=0, ack0=ack1=0.
REQ-019 IDLE, exactly one reqN high: grant N — owner<=N, tx_data<=dataN, tx_send<=1, go LAUNCH.
REQ-020 IDLE, req0 and req1 both high: grant the requester not equal to last_owner (round-robin); last_owner resets to 1 so req0 wins the first tie.
REQ-021 Latency: req sampled high in IDLE at edge k -> tx_send=1 and tx_data valid after edge k.
REQ-022 LAUNCH: hold tx_send=1 until tx_sent sampled 0, then tx_send<=0, go WAIT_DONE.
REQ-023 WAIT_DONE: on tx_sent sampled 1, go FINISH.
REQ-024 FINISH: ack<owner> pulses exactly one cycle; last_owner<=owner; go IDLE; IDLE occupied at least one cycle before next grant.
REQ-025 tx_data held constant from grant until state returns to IDLE.
REQ-026 32-bit timeout counter cleared at grant, increments each cycle in LAUNCH/WAIT_DONE; when it reaches TIMEOUT-1 without completion: tx_send<=0, timeout_err<=1, go FINISH (ack still issued).
REQ-027 err_clr high clears timeout_err next edge; simultaneous new timeout wins (flag stays 1).
REQ-028 reqN deasserted mid-transfer: ignored; transfer completes and ackN still pulses.
REQ-029 data changes after grant have no effect on tx_data.
REQ-030 tx_sent already 0 at grant (transmitter busy): LAUNCH waits until a 1->0 sequence is not required; first sampled 0 advances, timeout still applies.

Reset
REQ-031 rst high: state<=IDLE, tx_send=0, tx_data=8'h00, ack0=ack1=0, busy=0, owner=0, last_owner=1, timeout_err=0, counter=0, immediately and asynchronously.
REQ-032 rst asserted mid-transfer: transfer abandoned, no ack issued, tx_send drops asynchronously.
REQ-033 First grant possible on first rising edge after rst deasserts.

Verification
REQ-034 req0=1, data0=8'hA5, model holds tx_sent=1, drops 3 cycles after tx_send, rises 10 cycles later -> tx_data=8'hA5, tx_send high 3 cycles, ack0 single pulse, busy returns 0.
REQ-035 req0 and req1 both high after reset, data0=8'h11, data1=8'h22 -> bytes sent 8'h11 then 8'h22, ack0 before ack1; repeat with both held -> alternation 0,1,0,1.
REQ-036 TIMEOUT=16, tx_sent stuck 1 -> tx_send drops after 16 cycles, timeout_err=1, ackN pulses; err_clr pulse -> timeout_err=0.
REQ-037 rst pulsed during WAIT_DONE -> all outputs at reset values, no ack, next req granted normally.
REQ-038 req1 dropped and data1 changed 8'h3C->8'hFF during LAUNCH -> tx_data stays 8'h3C, ack1 still pulses once.
REQ-039 err_clr and timeout event on same edge -> timeout_err remains 1.
